// File: rtl/mmap_pkg.sv
// mmap_pkg: shared types and constants for the sequential-read front end.
//   state_t          FSM encoding used by mmap_seq_reader
//   DefaultBytesLog  log2 of the default beat width in bytes
//   DefaultStride    default byte-address step between consecutive beats
//   stride_bytes()   byte stride for a given log2 beat width
package mmap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DefaultBytesLog = 6;
    localparam int DefaultStride   = 1 << DefaultBytesLog;

    function automatic int stride_bytes(input int bytes_log);
        return 1 << bytes_log;
    endfunction

endpackage

// File: rtl/mmap_seq_reader.sv
// mmap_seq_reader: turns one {base, beat count} request into a stream of
// per-beat read addresses for the memory-mapped adapter, forwards the
// returned beats to a user data FIFO, and reports completion with the count.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_base_din/count_din   request (base byte address, length in beats)
//   req_write / req_full_n   request push / request accepted when high
//   read_addr_din/_write     per-beat address push into the adapter
//   read_addr_full_n         adapter address FIFO has room
//   read_data_dout           beat returned by the adapter
//   read_data_empty_n/_read  adapter data FIFO not empty / pop
//   data_din/_write          beat forwarded to the user FIFO / push
//   data_full_n              user FIFO has room
//   done_din/_write          completed beat count / completion push
//   done_full_n              completion FIFO has room
//
// All FIFO ports follow the same handshake: the producer raises *_write
// (or the consumer *_read) only when the matching full_n / empty_n is high,
// so a transfer happens on every clock edge where the strobe is high.
module mmap_seq_reader
    import mmap_pkg::*;
#(
    parameter int AddrWidth         = 64,
    parameter int DataWidth         = 512,
    parameter int DataWidthBytesLog = 6,
    parameter int CountWidth        = 32,
    parameter int MaxOutstandingLog = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AddrWidth-1:0]  req_base_din,
    input  logic [CountWidth-1:0] req_count_din,
    input  logic                  req_write,
    output logic                  req_full_n,
    output logic [AddrWidth-1:0]  read_addr_din,
    output logic                  read_addr_write,
    input  logic                  read_addr_full_n,
    input  logic [DataWidth-1:0]  read_data_dout,
    input  logic                  read_data_empty_n,
    output logic                  read_data_read,
    output logic [DataWidth-1:0]  data_din,
    output logic                  data_write,
    input  logic                  data_full_n,
    output logic [CountWidth-1:0] done_din,
    output logic                  done_write,
    input  logic                  done_full_n
);

    localparam int OutWidth = MaxOutstandingLog + 1;

    localparam logic [AddrWidth-1:0] Stride    = AddrWidth'(stride_bytes(DataWidthBytesLog));
    localparam logic [AddrWidth-1:0] AlignMask = ~(Stride - AddrWidth'(1));
    localparam logic [OutWidth-1:0]  OutMax    = OutWidth'(1) << MaxOutstandingLog;

    state_t                state_q, state_d;
    logic [CountWidth-1:0] issued_q, issued_d;
    logic [CountWidth-1:0] received_q, received_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic [OutWidth-1:0]   outstanding_q, outstanding_d;
    // The aligned base is loaded straight into next_addr; it is the first
    // address issued, so no separate base register is needed.
    logic [AddrWidth-1:0]  next_addr_q, next_addr_d;

    logic addr_fire;
    logic data_fire;

    // Held low during reset so nothing upstream pushes into a clearing block.
    assign req_full_n    = (state_q == IDLE) && !rst;
    assign read_addr_din = next_addr_q;
    assign done_din      = count_q;
    assign data_din      = read_data_dout;

    always_comb begin
        state_d         = state_q;
        issued_d        = issued_q;
        received_d      = received_q;
        count_d         = count_q;
        outstanding_d   = outstanding_q;
        next_addr_d     = next_addr_q;
        read_addr_write = 1'b0;
        read_data_read  = 1'b0;
        data_write      = 1'b0;
        done_write      = 1'b0;

        addr_fire = (state_q == ISSUE) && (issued_q < count_q) &&
                    read_addr_full_n && (outstanding_q < OutMax);
        // Beats are only accepted while a request is live; anything sitting
        // in the adapter FIFO during IDLE or DONE is left untouched.
        data_fire = ((state_q == ISSUE) || (state_q == DRAIN)) &&
                    read_data_empty_n && data_full_n && (received_q < count_q);

        read_addr_write = addr_fire;
        read_data_read  = data_fire;
        data_write      = data_fire;

        if (addr_fire) begin
            next_addr_d = next_addr_q + Stride;  // wraps modulo 2**AddrWidth
            issued_d    = issued_q + CountWidth'(1);
        end
        if (data_fire) begin
            received_d = received_q + CountWidth'(1);
        end
        // A simultaneous issue and return leaves the in-flight count as is.
        case ({addr_fire, data_fire})
            2'b10:   outstanding_d = outstanding_q + OutWidth'(1);
            2'b01:   outstanding_d = outstanding_q - OutWidth'(1);
            default: outstanding_d = outstanding_q;
        endcase

        case (state_q)
            IDLE: begin
                if (req_write) begin
                    next_addr_d   = req_base_din & AlignMask;
                    count_d       = req_count_din;
                    issued_d      = '0;
                    received_d    = '0;
                    outstanding_d = '0;
                    state_d       = (req_count_din == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (addr_fire && (issued_q + CountWidth'(1) == count_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (received_q == count_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_write = done_full_n;
                if (done_full_n) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            issued_q      <= '0;
            received_q    <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            next_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            issued_q      <= issued_d;
            received_q    <= received_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            next_addr_q   <= next_addr_d;
        end
    end

endmodule

// File: tb/tb_mmap_seq_reader.sv
// tb_mmap_seq_reader: directed bench for mmap_seq_reader. A behavioural
// adapter returns one beat per accepted address (beat contents derived from
// the address), and each scenario task checks addresses, beats and
// completions against values computed here from the request.
module tb_mmap_seq_reader;

    localparam int AW  = 64;
    localparam int DW  = 512;
    localparam int CW  = 32;
    localparam int MOL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] req_base_din = '0;
    logic [CW-1:0] req_count_din = '0;
    logic          req_write = 1'b0;
    logic          req_full_n;
    logic [AW-1:0] read_addr_din;
    logic          read_addr_write;
    logic          read_addr_full_n = 1'b1;
    logic [DW-1:0] read_data_dout;
    logic          read_data_empty_n;
    logic          read_data_read;
    logic [DW-1:0] data_din;
    logic          data_write;
    logic          data_full_n = 1'b1;
    logic [CW-1:0] done_din;
    logic          done_write;
    logic          done_full_n = 1'b1;

    int assertions = 0;
    int failures   = 0;

    mmap_seq_reader #(
        .AddrWidth(AW), .DataWidth(DW), .DataWidthBytesLog(6),
        .CountWidth(CW), .MaxOutstandingLog(MOL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_base_din(req_base_din), .req_count_din(req_count_din),
        .req_write(req_write), .req_full_n(req_full_n),
        .read_addr_din(read_addr_din), .read_addr_write(read_addr_write),
        .read_addr_full_n(read_addr_full_n),
        .read_data_dout(read_data_dout), .read_data_empty_n(read_data_empty_n),
        .read_data_read(read_data_read),
        .data_din(data_din), .data_write(data_write), .data_full_n(data_full_n),
        .done_din(done_din), .done_write(done_write), .done_full_n(done_full_n)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural adapter + monitors ----------------
    int            cyc = 0;
    logic [DW-1:0] adq[$];
    logic [DW-1:0] rd_front = '0;
    int            adq_n = 0;
    logic          data_en = 1'b1;
    logic          rand_mode = 1'b0;
    logic          a_fire = 1'b0;
    logic          d_fire = 1'b0;
    logic [AW-1:0] a_addr = '0;

    logic [AW-1:0] addr_log[$];
    int            addr_cyc[$];
    logic [DW-1:0] data_log[$];
    logic [CW-1:0] done_log[$];
    int            done_cyc[$];
    int            req_cyc = 0;

    assign read_data_empty_n = data_en && (adq_n != 0);
    assign read_data_dout    = rd_front;

    function automatic logic [DW-1:0] beat_of(input logic [AW-1:0] a);
        return {8{a ^ 64'h5A5A_0000_C3C3_0000}};
    endfunction

    always @(negedge clk) begin
        a_fire = 1'b0;
        d_fire = 1'b0;
        if (!rst) begin
            if (read_addr_write && read_addr_full_n) begin
                a_fire = 1'b1;
                a_addr = read_addr_din;
                addr_log.push_back(read_addr_din);
                addr_cyc.push_back(cyc);
            end
            d_fire = read_data_read;
            if (data_write) data_log.push_back(data_din);
            if (done_write) begin
                done_log.push_back(done_din);
                done_cyc.push_back(cyc);
            end
            if (req_write && req_full_n) req_cyc = cyc;
        end
    end

    always @(posedge clk) begin
        cyc++;
        #2;
        if (rst) begin
            adq.delete();
        end else begin
            if (d_fire && adq.size() > 0) void'(adq.pop_front());
            if (a_fire) adq.push_back(beat_of(a_addr));
        end
        adq_n    = adq.size();
        rd_front = (adq.size() > 0) ? adq[0] : '0;
    end

    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            read_addr_full_n = 1'($urandom_range(0, 1));
            data_full_n      = 1'($urandom_range(0, 1));
            done_full_n      = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_logs();
        addr_log.delete(); addr_cyc.delete(); data_log.delete();
        done_log.delete(); done_cyc.delete();
    endtask

    task automatic send_req(input logic [AW-1:0] b, input logic [CW-1:0] c);
        int t = 0;
        while (!req_full_n && t < 50) begin tick(1); t++; end
        assertions++;
        if (req_full_n !== 1'b1) begin
            failures++;
            $display("FAIL send_req_ready: req_full_n=%b required 1", req_full_n);
        end
        req_base_din = b; req_count_din = c; req_write = 1'b1;
        tick(1);
        req_write = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int t = 0;
        while (done_log.size() < n && t < budget) begin tick(1); t++; end
        assertions++;
        if (done_log.size() < n) begin
            failures++;
            $display("FAIL done_timeout: completions=%0d required %0d", done_log.size(), n);
        end
    endtask

    // Checks n sequential addresses from base and the matching beats in order.
    task automatic check_stream(input string nm, input logic [AW-1:0] base, input int n);
        logic [AW-1:0] ea, oa;
        logic [DW-1:0] od;
        assertions++;
        if (addr_log.size() != n || data_log.size() != n) begin
            failures++;
            $display("FAIL %s_counts: addrs=%0d beats=%0d required %0d", nm, addr_log.size(), data_log.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            ea = base + AW'(i) * AW'(64);
            oa = (i < addr_log.size()) ? addr_log[i] : 'x;
            od = (i < data_log.size()) ? data_log[i] : 'x;
            assertions++;
            if (oa !== ea) begin
                failures++;
                $display("FAIL %s_addr[%0d]: got %h required %h", nm, i, oa, ea);
            end
            assertions++;
            if (od !== beat_of(ea)) begin
                failures++;
                $display("FAIL %s_beat[%0d]: got %h required %h", nm, i, od[63:0], ea ^ 64'h5A5A_0000_C3C3_0000);
            end
        end
    endtask

    task automatic check_done(input string nm, input logic [CW-1:0] exp);
        assertions++;
        if (done_log.size() != 1 || done_log[0] !== exp) begin
            failures++;
            $display("FAIL %s_done: completions=%0d first=%0d required one of %0d", nm,
                     done_log.size(), (done_log.size() > 0) ? done_log[0] : '0, exp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tick(3);
        assertions++;
        if ({req_full_n, read_addr_write, read_data_read, data_write, done_write} !== 5'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b required 00000",
                     {req_full_n, read_addr_write, read_data_read, data_write, done_write});
        end
        assertions++;
        if (read_addr_din !== '0 || done_din !== '0) begin
            failures++;
            $display("FAIL reset_values: addr=%h done=%0d required 0", read_addr_din, done_din);
        end
        rst = 1'b0;
        tick(1);
        assertions++;
        if (req_full_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: req_full_n=%b required 1", req_full_n);
        end
    endtask

    task automatic test_basic();
        clear_logs();
        send_req(64'h1000, 4);
        wait_done(1, 100);
        tick(5);
        check_stream("basic", 64'h1000, 4);
        check_done("basic", 4);
        assertions++;
        if (addr_cyc.size() != 4 || addr_cyc[3] - addr_cyc[0] != 3) begin
            failures++;
            $display("FAIL basic_back_to_back: %0d addrs span %0d cycles required 4 in 3", addr_cyc.size(),
                     (addr_cyc.size() == 4) ? addr_cyc[3] - addr_cyc[0] : -1);
        end
        assertions++;
        if (req_full_n !== 1'b1) begin
            failures++;
            $display("FAIL basic_req_ready: req_full_n=%b required 1", req_full_n);
        end
    endtask

    task automatic test_zero_count();
        clear_logs();
        send_req(64'h3000, 0);
        wait_done(1, 10);
        tick(3);
        check_done("zero", 0);
        assertions++;
        if (addr_log.size() != 0) begin
            failures++;
            $display("FAIL zero_addrs: got %0d required 0", addr_log.size());
        end
        assertions++;
        if (done_cyc.size() == 0 || done_cyc[0] - req_cyc > 2) begin
            failures++;
            $display("FAIL zero_latency: got %0d cycles required <= 2",
                     (done_cyc.size() > 0) ? done_cyc[0] - req_cyc : -1);
        end
    endtask

    task automatic test_outstanding();
        clear_logs();
        data_en = 1'b0;
        send_req(64'h4000, 10);
        tick(20);
        assertions++;
        if (addr_log.size() != 4) begin
            failures++;
            $display("FAIL outstanding_cap: got %0d addrs required 4", addr_log.size());
        end
        data_en = 1'b1;
        tick(1);
        data_en = 1'b0;
        tick(10);
        assertions++;
        if (addr_log.size() != 5 || data_log.size() != 1) begin
            failures++;
            $display("FAIL outstanding_one_more: got %0d addrs %0d beats required 5 and 1",
                     addr_log.size(), data_log.size());
        end
        data_en = 1'b1;
        wait_done(1, 200);
        tick(2);
        check_stream("outstanding", 64'h4000, 10);
        check_done("outstanding", 10);
    endtask

    task automatic test_wrap_align();
        clear_logs();
        send_req(64'hFFFF_FFFF_FFFF_FFC0, 2);
        wait_done(1, 100);
        tick(2);
        check_stream("wrap", 64'hFFFF_FFFF_FFFF_FFC0, 2);
        check_done("wrap", 2);
        clear_logs();
        send_req(64'h1010, 1);
        wait_done(1, 100);
        tick(2);
        check_stream("align", 64'h1000, 1);
        check_done("align", 1);
    endtask

    task automatic test_backpressure();
        clear_logs();
        rand_mode = 1'b1;
        send_req(64'h8000, 100);
        wait_done(1, 3000);
        rand_mode = 1'b0;
        tick(1);
        read_addr_full_n = 1'b1; data_full_n = 1'b1; done_full_n = 1'b1;
        tick(5);
        check_stream("backpressure", 64'h8000, 100);
        check_done("backpressure", 100);
    endtask

    task automatic test_reset_mid();
        int t = 0;
        clear_logs();
        data_en = 1'b0;
        send_req(64'h5000, 8);
        while (addr_log.size() < 3 && t < 50) begin tick(1); t++; end
        rst = 1'b1;
        #1;
        assertions++;
        if ({req_full_n, read_addr_write, read_data_read, data_write, done_write} !== 5'b0 ||
            read_addr_din !== '0 || done_din !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: strobes=%b addr=%h done=%0d required all 0",
                     {req_full_n, read_addr_write, read_data_read, data_write, done_write},
                     read_addr_din, done_din);
        end
        assertions++;
        if (addr_log.size() != 3) begin
            failures++;
            $display("FAIL midreset_issued: got %0d addrs required 3", addr_log.size());
        end
        tick(2);
        rst = 1'b0;
        data_en = 1'b1;
        tick(1);
        assertions++;
        if (req_full_n !== 1'b1) begin
            failures++;
            $display("FAIL midreset_release: req_full_n=%b required 1", req_full_n);
        end
        clear_logs();
        send_req(64'h2000, 1);
        wait_done(1, 100);
        tick(2);
        check_stream("midreset_new", 64'h2000, 1);
        check_done("midreset_new", 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_outstanding();
        test_wrap_align();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/mmap_seq_reader.md
Name: mmap_seq_reader

Overview:
- Sequential-read front end sitting directly upstream of the async memory-mapped AXI adapter.
- Accepts one request at a time, {base address, beat count}, and expands it into per-beat addresses pushed into the adapter's read-address FIFO port.
- Pops the returned read data from the adapter's read-data FIFO port and forwards it to a user data FIFO.
- Bounds outstanding reads and reports completion with the beat count.

Parameters:
- AddrWidth, 64, byte-address width; matches the adapter.
- DataWidth, 512, beat width in bits.
- DataWidthBytesLog, 6, log2(DataWidth/8); address stride per beat = 1<<DataWidthBytesLog.
- CountWidth, 32, width of the beat-count field.
- MaxOutstandingLog, 6, maximum in-flight beats = 2**MaxOutstandingLog; must not exceed the adapter's read buffer depth.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_base_din  in  AddrWidth  request base byte address
- req_count_din  in  CountWidth  request length in beats
- req_write  in  1  request push
- req_full_n  out  1  request accepted when high
- read_addr_din  out  AddrWidth  per-beat address to adapter
- read_addr_write  out  1  address push
- read_addr_full_n  in  1  adapter address FIFO not full
- read_data_dout  in  DataWidth  returned beat from adapter
- read_data_empty_n  in  1  adapter data FIFO not empty
- read_data_read  out  1  pop adapter data
- data_din  out  DataWidth  beat to user FIFO
- data_write  out  1  user FIFO push
- data_full_n  in  1  user FIFO not full
- done_din  out  CountWidth  completed beat count
- done_write  out  1  completion push
- done_full_n  in  1  completion FIFO not full

Behaviour:
- One clock. Reset is asynchronous and active-high on rst; all flops clear immediately on assertion.
- Reset values:
  - state = IDLE; issued, received, outstanding, base, count, next_addr all 0.
  - req_full_n = 0 while rst is high, 1 from the first cycle after release.
  - read_addr_write, read_data_read, data_write and done_write = 0; read_addr_din = 0; done_din = 0.
- Counters:
  - issued and received are CountWidth wide.
  - outstanding is MaxOutstandingLog+1 wide, equal to issued minus received.
  - Issue and return in the same cycle leave outstanding unchanged.
- State IDLE:
  - req_full_n = 1.
  - On req_write, latch base with its low DataWidthBytesLog bits forced to 0, latch count, set next_addr = masked base, clear counters.
  - Next state is DONE if count == 0, else ISSUE.
  - read_data_read = 0 in IDLE; stray data is never consumed.
- State ISSUE:
  - read_addr_write = (issued < count) && read_addr_full_n && (outstanding < 2**MaxOutstandingLog).
  - read_addr_din = next_addr, a registered value.
  - On each push: next_addr += stride, computed modulo 2**AddrWidth (wrap, no error); issued += 1.
  - When the final address is pushed, go to DRAIN the next cycle.
- Data path (ISSUE and DRAIN):
  - read_data_read = read_data_empty_n && data_full_n && (received < count).
  - data_write = read_data_read; data_din = read_data_dout, combinational pass-through with zero latency.
  - received += 1 per pop.
- State DRAIN: when received == count, go to DONE.
- State DONE:
  - done_write = done_full_n; done_din = count.
  - On push, return to IDLE; stay in DONE while done_full_n = 0.
- req_full_n = 0 in every state except IDLE; exactly one request is in flight.
- Backpressure on read_addr_full_n or data_full_n stalls only the affected side: no duplicated address, no dropped beat.
- Reset mid-operation:
  - Returns immediately to the reset state, abandoning the request.
  - rst must be shared with the adapter so in-flight responses are flushed.
- Throughput: one address per cycle and one beat per cycle, both sustainable simultaneously.

Decomposition:
- Shared package mmap_pkg: state enum {IDLE, ISSUE, DRAIN, DONE} and a stride localparam derived from DataWidthBytesLog.
- Flat module; no sub-module. Counters and FSM sit in a single always block plus combinational handshakes.

Test Plan:
- base 0x1000, count 4, all ready -> read_addr_din 0x1000, 0x1040, 0x1080, 0x10C0 on 4 consecutive cycles; 4 beats forwarded in order; done_din = 4 exactly once; req_full_n returns to 1.
- count 0 -> no read_addr_write; done_write with done_din = 0 within 2 cycles of the request.
- MaxOutstandingLog = 2, count 10, read_data_empty_n held 0 -> exactly 4 addresses then stall; supply one beat -> exactly one more address issued.
- base 0xFFFF_FFFF_FFFF_FFC0, count 2 -> addresses 0xFFFF_FFFF_FFFF_FFC0 then 0x0; unaligned base 0x1010 -> first address 0x1000.
- Toggle data_full_n and read_addr_full_n randomly, count 100 -> 100 unique sequential addresses; 100 beats matching source order; done_din = 100.
- Assert rst after 3 addresses in ISSUE -> all outputs 0 immediately; after release req_full_n = 1, and a new request base 0x2000 count 1 issues 0x2000.
